spi_reg_bank: RTL and testbench

SPI_REG_BANK -- requirements
Module: spi_reg_bank

---
 rtl/spi_reg_bank_if.sv | 25 ++
 rtl/spi_reg_bank.sv | 176 +++++++++++++++++
 tb/tb_spi_reg_bank.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_bank_if.sv
// Command-side bus of the SPI register bank: write/read requests toward the
// bank and the readback, error and ready indications coming back.
interface spi_reg_bank_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic              cmd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              addr_err;

    modport master (
        output wr_en, rd_en, addr, wr_data,
        input  cmd_ready, rd_data, rd_valid, addr_err
    );

    modport slave (
        input  wr_en, rd_en, addr, wr_data,
        output cmd_ready, rd_data, rd_valid, addr_err
    );
endinterface

// File: rtl/spi_reg_bank.sv
// Double-buffered register bank: commands fill the buffer array, and a write of
// bit 0 to the transfer register copies the whole buffer into the active array.
module spi_reg_bank #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 256,
    parameter int XFER_ADDR = 255,
    parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}}
) (
    input  logic               clk,
    input  logic               reset,
    spi_reg_bank_if.slave      bus,
    input  logic [ADDR_W-1:0]  act_addr,
    output logic [DATA_W-1:0]  act_data,
    output logic               busy,
    output logic               xfer_done
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W:0]    DEPTH_A  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0]  XFER_A   = ADDR_W'(XFER_ADDR);
    localparam logic [IDX_W-1:0]   XFER_IDX = IDX_W'(XFER_ADDR);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COPY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               busy_r;
    logic               xfer_done_r;
    logic [DATA_W-1:0]  rd_data_r;
    logic               rd_valid_r;
    logic               addr_err_r;
    logic [DATA_W-1:0]  act_data_r;

    logic [DATA_W-1:0]  buffer_r [DEPTH];
    logic [DATA_W-1:0]  active_r [DEPTH];

    logic               cmd_ready_s;
    logic               addr_ok_s;
    logic               act_ok_s;
    logic               wr_acc_s;
    logic               rd_acc_s;
    logic               cmd_acc_s;
    logic               start_s;
    logic               copy_s;
    logic               done_s;
    logic [IDX_W-1:0]   cmd_idx_s;
    logic [IDX_W-1:0]   act_idx_s;
    logic [IDX_W-1:0]   cnt_idx_s;

    assign cmd_ready_s = ~busy_r;
    assign addr_ok_s   = ({1'b0, bus.addr} < DEPTH_A);
    assign act_ok_s    = ({1'b0, act_addr} < DEPTH_A);
    assign cmd_idx_s   = bus.addr[IDX_W-1:0];
    assign act_idx_s   = act_addr[IDX_W-1:0];
    assign cnt_idx_s   = cnt_r[IDX_W-1:0];

    // A simultaneous write and read is treated as a write only.
    assign wr_acc_s  = bus.wr_en & cmd_ready_s;
    assign rd_acc_s  = bus.rd_en & ~bus.wr_en & cmd_ready_s;
    assign cmd_acc_s = (bus.wr_en | bus.rd_en) & cmd_ready_s;
    assign start_s   = wr_acc_s & addr_ok_s & (bus.addr == XFER_A) & bus.wr_data[0];
    assign copy_s    = (state_r == ST_COPY);
    assign done_s    = (state_r == ST_DONE);

    // Next-state and copy-counter logic of the transfer FSM.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = {CNT_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_COPY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COPY: begin
                if (cnt_r == LAST_CNT) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_COPY;
                    cnt_nxt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, counter and the status flags derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            busy_r      <= 1'b0;
            xfer_done_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            xfer_done_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Command-side readback and error pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_r  <= {DATA_W{1'b0}};
            rd_valid_r <= 1'b0;
            addr_err_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_acc_s;
            addr_err_r <= cmd_acc_s & ~addr_ok_s;
            if (rd_acc_s) begin
                rd_data_r <= addr_ok_s ? buffer_r[cmd_idx_s] : {DATA_W{1'b0}};
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    // Buffer array: command writes, and the transfer bit self-clears in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                buffer_r[i] <= RST_VAL;
            end
        end else if (wr_acc_s && addr_ok_s) begin
            buffer_r[cmd_idx_s] <= bus.wr_data;
        end else if (done_s) begin
            buffer_r[XFER_IDX][0] <= 1'b0;
        end
    end

    // Active array: one entry copied per COPY cycle, transfer bit cleared in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                active_r[i] <= RST_VAL;
            end
        end else if (copy_s) begin
            active_r[cnt_idx_s] <= buffer_r[cnt_idx_s];
        end else if (done_s) begin
            active_r[XFER_IDX][0] <= 1'b0;
        end
    end

    // Model-side readback; partially copied contents are visible during COPY.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_data_r <= {DATA_W{1'b0}};
        end else begin
            act_data_r <= act_ok_s ? active_r[act_idx_s] : {DATA_W{1'b0}};
        end
    end

    assign bus.cmd_ready = cmd_ready_s;
    assign bus.rd_data   = rd_data_r;
    assign bus.rd_valid  = rd_valid_r;
    assign bus.addr_err  = addr_err_r;
    assign act_data      = act_data_r;
    assign busy          = busy_r;
    assign xfer_done     = xfer_done_r;
endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: table of single commands checked through an
// expected-output queue, plus hand-written transfer and reset sequences.
module tb_spi_reg_bank;
    logic        clk;
    logic        reset;
    logic [12:0] act_addr;
    logic [7:0]  act_data;
    logic        busy;
    logic        xfer_done;

    int n_cmp  = 0;
    int n_fail = 0;

    spi_reg_bank_if #(.ADDR_W(13), .DATA_W(8)) bus ();

    spi_reg_bank #(
        .ADDR_W(13), .DATA_W(8), .DEPTH(256), .XFER_ADDR(255), .RST_VAL(8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .act_addr  (act_addr),
        .act_data  (act_data),
        .busy      (busy),
        .xfer_done (xfer_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       valid;
        logic       err;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [12:0] addr;
        logic [7:0]  wdata;
        logic        ev;
        logic        ee;
        logic [7:0]  ed;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock edge, then compare any command-side output with the queue head.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (bus.rd_valid || bus.addr_err) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got rd_valid=%0b addr_err=%0b expected none",
                         bus.rd_valid, bus.addr_err);
            end else begin
                e = exp_q.pop_front();
                if (bus.rd_valid !== e.valid || bus.addr_err !== e.err ||
                    (e.valid && bus.rd_data !== e.data)) begin
                    n_fail++;
                    $display("FAIL cmd_output: got v=%0b e=%0b d=%0h expected v=%0b e=%0b d=%0h",
                             bus.rd_valid, bus.addr_err, bus.rd_data, e.valid, e.err, e.data);
                end
            end
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL missing_output: got no response expected %0d pending", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wr_cmd(input logic [12:0] a, input logic [7:0] d);
        bus.wr_en = 1'b1; bus.addr = a; bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic rd_cmd(input logic [12:0] a, input logic [7:0] d);
        bus.rd_en = 1'b1; bus.addr = a;
        exp_q.push_back('{valid: 1'b1, err: 1'b0, data: d});
        step();
        bus.rd_en = 1'b0;
    endtask

    task automatic act_chk(input string name, input logic [12:0] a, input logic [7:0] d);
        act_addr = a;
        step();
        chk(name, {24'h0, act_data}, {24'h0, d});
    endtask

    // Starts a transfer and counts busy cycles; with poke, also probes COPY.
    task automatic run_xfer(input bit poke, output int nbusy, output int ndone, output int done_at);
        wr_cmd(13'h0FF, 8'h01);
        nbusy = 0; ndone = 0; done_at = 0;
        while (busy && nbusy < 400) begin
            nbusy++;
            if (xfer_done) begin
                ndone++;
                done_at = nbusy;
            end
            if (poke) begin
                if (nbusy == 3) chk("copy_partial_before", {24'h0, act_data}, 32'h00);
                if (nbusy == 20) chk("copy_partial_after", {24'h0, act_data}, 32'h3C);
                if (nbusy == 5) begin
                    chk("cmd_ready_busy", {31'h0, bus.cmd_ready}, 32'h0);
                    bus.wr_en = 1'b1; bus.addr = 13'h005; bus.wr_data = 8'h99;
                end
                if (nbusy == 6) begin
                    bus.wr_en = 1'b0; bus.rd_en = 1'b1; bus.addr = 13'h120;
                end
                if (nbusy == 7) bus.rd_en = 1'b0;
            end
            step();
        end
    endtask

    initial begin
        int nb, nd, da;
        reset = 1'b0; act_addr = 13'h0;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = 13'h0; bus.wr_data = 8'h0;

        vecs[0]  = '{1'b1, 1'b0, 13'h0014, 8'hA5, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 13'h0014, 8'h00, 1'b1, 1'b0, 8'hA5};
        vecs[2]  = '{1'b1, 1'b0, 13'h0120, 8'h77, 1'b0, 1'b1, 8'h00};
        vecs[3]  = '{1'b0, 1'b1, 13'h0120, 8'h00, 1'b1, 1'b1, 8'h00};
        vecs[4]  = '{1'b0, 1'b1, 13'h0020, 8'h00, 1'b1, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, 1'b1, 13'h0030, 8'h5A, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 1'b1, 13'h0030, 8'h00, 1'b1, 1'b0, 8'h5A};
        vecs[7]  = '{1'b1, 1'b0, 13'h00FF, 8'h02, 1'b0, 1'b0, 8'h00};
        vecs[8]  = '{1'b0, 1'b1, 13'h00FF, 8'h00, 1'b1, 1'b0, 8'h02};
        vecs[9]  = '{1'b1, 1'b0, 13'h0000, 8'h11, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 1'b1, 13'h0000, 8'h00, 1'b1, 1'b0, 8'h11};
        vecs[11] = '{1'b1, 1'b0, 13'h00FE, 8'hEE, 1'b0, 1'b0, 8'h00};
        vecs[12] = '{1'b0, 1'b1, 13'h0100, 8'h00, 1'b1, 1'b1, 8'h00};
        vecs[13] = '{1'b0, 1'b1, 13'h1FFF, 8'h00, 1'b1, 1'b1, 8'h00};

        #1;
        chk("rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
        chk("rst_busy",      {31'h0, busy},          32'h0);
        chk("rst_rd_valid",  {31'h0, bus.rd_valid},  32'h0);
        chk("rst_addr_err",  {31'h0, bus.addr_err},  32'h0);
        chk("rst_xfer_done", {31'h0, xfer_done},     32'h0);
        chk("rst_rd_data",   {24'h0, bus.rd_data},   32'h0);
        chk("rst_act_data",  {24'h0, act_data},      32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            bus.wr_en = vecs[i].wr; bus.rd_en = vecs[i].rd;
            bus.addr = vecs[i].addr; bus.wr_data = vecs[i].wdata;
            if (vecs[i].ev || vecs[i].ee)
                exp_q.push_back('{valid: vecs[i].ev, err: vecs[i].ee, data: vecs[i].ed});
            step();
            bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        end
        chk("busy_after_plain_xfer_write", {31'h0, busy}, 32'h0);
        act_chk("act_0x14_before_xfer", 13'h014, 8'h00);

        // Full transfer with commands attempted while busy.
        wr_cmd(13'h005, 8'h3C);
        act_addr = 13'h005;
        run_xfer(1'b1, nb, nd, da);
        chk("xfer_busy_cycles", nb, 32'd257);
        chk("xfer_done_count", nd, 32'd1);
        chk("xfer_done_cycle", da, 32'd257);
        chk("cmd_ready_after", {31'h0, bus.cmd_ready}, 32'h1);
        act_chk("act_0x05_after", 13'h005, 8'h3C);
        act_chk("act_0x14_after", 13'h014, 8'hA5);
        act_chk("act_0xff_cleared", 13'h0FF, 8'h00);
        act_chk("act_out_of_range", 13'h0120, 8'h00);
        rd_cmd(13'h0FF, 8'h00);
        rd_cmd(13'h005, 8'h3C);

        // Reset during COPY at count 100.
        act_addr = 13'h005;
        wr_cmd(13'h0FF, 8'h01);
        repeat (100) step();
        chk("mid_copy_busy", {31'h0, busy}, 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("mrst_busy",      {31'h0, busy},          32'h0);
        chk("mrst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
        chk("mrst_act_data",  {24'h0, act_data},      32'h0);
        chk("mrst_rd_data",   {24'h0, bus.rd_data},   32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mrst_no_xfer_done", {31'h0, xfer_done}, 32'h0);
        end
        reset = 1'b1;
        act_chk("mrst_act_0x05", 13'h005, 8'h00);
        act_chk("mrst_act_0x14", 13'h014, 8'h00);
        rd_cmd(13'h005, 8'h00);

        // A fresh transfer after the aborted one.
        wr_cmd(13'h007, 8'h42);
        run_xfer(1'b0, nb, nd, da);
        chk("xfer2_busy_cycles", nb, 32'd257);
        chk("xfer2_done_count", nd, 32'd1);
        act_chk("xfer2_act_0x07", 13'h007, 8'h42);
        act_chk("xfer2_act_0xff", 13'h0FF, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
